// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch unit (I)
// and the load/store unit (D). One access at a time: IDLE picks an owner and
// registers its payload, ACCESS drives the memory until MemAck, and RESP
// pulses the owner's Ready for one cycle. D has priority over I. A saturating
// streak counter forces a pending fetch through after STREAK back-to-back data
// grants.
module mem_port_arbiter #(
  parameter int unsigned STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        IReq,
  input  logic [31:0] IAdr,
  output logic        IReady,
  output logic [31:0] IRData,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAdr,
  input  logic [31:0] DWData,
  input  logic [3:0]  DByteEn,
  output logic        DReady,
  output logic [31:0] DRData,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAdr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STREAK);

  state_t      state_q, state_d;
  logic        owner_i_q, owner_i_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_byteen_q, mem_byteen_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        grant_i;

  // Next-state logic: owner selection, payload capture, streak update and
  // read-data capture on the memory acknowledge.
  always_comb begin
    state_d      = state_q;
    owner_i_d    = owner_i_q;
    streak_d     = streak_q;
    mem_write_d  = mem_write_q;
    mem_adr_d    = mem_adr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_byteen_d = mem_byteen_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    grant_i      = IReq && (!DReq || (streak_q == STREAK_MAX));

    case (state_q)
      IDLE: begin
        if (DReq || IReq) begin
          state_d = ACCESS;
          if (grant_i) begin
            owner_i_d    = 1'b1;
            mem_write_d  = 1'b0;
            mem_adr_d    = IAdr;
            mem_wdata_d  = 32'h0;
            mem_byteen_d = 4'b0000;
            streak_d     = 4'd0;
          end else begin
            owner_i_d    = 1'b0;
            mem_write_d  = DWrite;
            mem_adr_d    = DAdr;
            mem_wdata_d  = DWData;
            mem_byteen_d = DWrite ? DByteEn : 4'b0000;
            if (!IReq) begin
              streak_d = 4'd0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end
      ACCESS: begin
        if (MemAck) begin
          state_d = RESP;
          if (owner_i_q) begin
            irdata_d = MemRData;
          end else begin
            drdata_d = mem_write_q ? 32'h0 : MemRData;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and payload registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_i_q    <= 1'b0;
      streak_q     <= 4'd0;
      mem_write_q  <= 1'b0;
      mem_adr_q    <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_byteen_q <= 4'b0000;
      irdata_q     <= 32'h0;
      drdata_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_i_q    <= owner_i_d;
      streak_q     <= streak_d;
      mem_write_q  <= mem_write_d;
      mem_adr_q    <= mem_adr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_byteen_q <= mem_byteen_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
    end
  end

  assign MemReq    = (state_q == ACCESS);
  assign MemWrite  = mem_write_q;
  assign MemAdr    = mem_adr_q;
  assign MemWData  = mem_wdata_q;
  assign MemByteEn = mem_byteen_q;
  assign IReady    = (state_q == RESP) && owner_i_q;
  assign DReady    = (state_q == RESP) && !owner_i_q;
  assign IRData    = irdata_q;
  assign DRData    = drdata_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a cycle from the active
// rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IReq;
  logic [31:0] IAdr;
  logic        IReady;
  logic [31:0] IRData;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAdr;
  logic [31:0] DWData;
  logic [3:0]  DByteEn;
  logic        DReady;
  logic [31:0] DRData;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] MemAdr;
  logic [31:0] MemWData;
  logic [3:0]  MemByteEn;
  logic [31:0] MemRData;
  logic        MemAck;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RDATA_SALT = 32'h5A5A_0000;

  mem_port_arbiter #(.STREAK(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .IReq      (IReq),
    .IAdr      (IAdr),
    .IReady    (IReady),
    .IRData    (IRData),
    .DReq      (DReq),
    .DWrite    (DWrite),
    .DAdr      (DAdr),
    .DWData    (DWData),
    .DByteEn   (DByteEn),
    .DReady    (DReady),
    .DRData    (DRData),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .MemAdr    (MemAdr),
    .MemWData  (MemWData),
    .MemByteEn (MemByteEn),
    .MemRData  (MemRData),
    .MemAck    (MemAck),
    .Busy      (Busy)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Hard stop in case something goes badly wrong
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iadr,
                               input logic dreq, input logic dwrite,
                               input logic [31:0] dadr, input logic [31:0] dwdata,
                               input logic [3:0] dbyteen);
    IReq    = ireq;
    IAdr    = iadr;
    DReq    = dreq;
    DWrite  = dwrite;
    DAdr    = dadr;
    DWData  = dwdata;
    DByteEn = dbyteen;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic grantIsI [10];
    int   nGrants;
    int   iReadyCyc [2];
    int   nIReady;
    int   bothHigh;

    reset_n  = 1'b0;
    MemAck   = 1'b0;
    MemRData = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();

    // Reset values
    checkOutput("rst_memreq", {31'h0, MemReq}, 32'h0);
    checkOutput("rst_busy", {31'h0, Busy}, 32'h0);
    checkOutput("rst_memadr", MemAdr, 32'h0);
    checkOutput("rst_memwrite", {31'h0, MemWrite}, 32'h0);
    checkOutput("rst_ready", {30'h0, IReady, DReady}, 32'h0);
    checkOutput("rst_rdata", IRData | DRData | MemWData, 32'h0);
    reset_n = 1'b1;
    tick();

    // Single load with immediate acknowledge
    $display("[TB] single load");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    tick();
    checkOutput("ld_memreq", {31'h0, MemReq}, 32'h1);
    checkOutput("ld_memadr", MemAdr, 32'h100);
    checkOutput("ld_byteen", {28'h0, MemByteEn}, 32'h0);
    checkOutput("ld_memwrite", {31'h0, MemWrite}, 32'h0);
    checkOutput("ld_dready_early", {31'h0, DReady}, 32'h0);
    MemAck   = 1'b1;
    MemRData = 32'hDEAD_BEEF;
    tick();
    checkOutput("ld_dready", {31'h0, DReady}, 32'h1);
    checkOutput("ld_ireadyx", {31'h0, IReady}, 32'h0);
    checkOutput("ld_drdata", DRData, 32'hDEAD_BEEF);
    checkOutput("ld_memreq_off", {31'h0, MemReq}, 32'h0);
    MemAck = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("ld_dready_once", {31'h0, DReady}, 32'h0);
    checkOutput("ld_idle", {31'h0, Busy}, 32'h0);
    checkOutput("ld_drdata_hold", DRData, 32'hDEAD_BEEF);

    // Store with two wait states; input payload changes mid-access
    $display("[TB] store with wait states");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h204, 32'h0000_AB00, 4'b0010);
    tick();
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("st_memreq_c%0d", c), {31'h0, MemReq}, 32'h1);
      checkOutput($sformatf("st_memwrite_c%0d", c), {31'h0, MemWrite}, 32'h1);
      checkOutput($sformatf("st_memadr_c%0d", c), MemAdr, 32'h204);
      checkOutput($sformatf("st_wdata_c%0d", c), MemWData, 32'h0000_AB00);
      checkOutput($sformatf("st_byteen_c%0d", c), {28'h0, MemByteEn}, 32'h2);
      checkOutput($sformatf("st_dready_c%0d", c), {31'h0, DReady}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFF0, 32'h1234_5678, 4'hF);
      if (c == 3) begin
        MemAck   = 1'b1;
        MemRData = 32'h7777_7777;
      end
      tick();
    end
    checkOutput("st_dready", {31'h0, DReady}, 32'h1);
    checkOutput("st_drdata", DRData, 32'h0);
    MemAck = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("st_idle", {31'h0, Busy}, 32'h0);

    // Contention: D served first, then I
    $display("[TB] contention");
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    checkOutput("ct_first_adr", MemAdr, 32'h80);
    MemAck   = 1'b1;
    MemRData = 32'h1111_0080;
    tick();
    checkOutput("ct_dready", {31'h0, DReady}, 32'h1);
    checkOutput("ct_drdata", DRData, 32'h1111_0080);
    MemAck = 1'b0;
    DReq   = 1'b0;
    tick();
    checkOutput("ct_gap_idle", {31'h0, Busy}, 32'h0);
    tick();
    checkOutput("ct_second_adr", MemAdr, 32'h40);
    checkOutput("ct_second_req", {31'h0, MemReq}, 32'h1);
    checkOutput("ct_fetch_wr", {27'h0, MemByteEn, MemWrite}, 32'h0);
    MemAck   = 1'b1;
    MemRData = 32'hCAFE_0040;
    tick();
    checkOutput("ct_iready", {30'h0, IReady, DReady}, 32'h2);
    checkOutput("ct_irdata", IRData, 32'hCAFE_0040);
    MemAck = 1'b0;
    IReq   = 1'b0;
    tick();
    checkOutput("ct_iready_once", {31'h0, IReady}, 32'h0);

    // Spurious acknowledge while idle
    $display("[TB] spurious ack in idle");
    MemAck   = 1'b1;
    MemRData = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("sp_state_c%0d", c), {29'h0, Busy, MemReq, IReady | DReady}, 32'h0);
    end
    checkOutput("sp_irdata", IRData, 32'hCAFE_0040);
    checkOutput("sp_drdata", DRData, 32'h1111_0080);
    MemAck = 1'b0;
    tick();

    // Starvation bound: both requesters held, immediate acknowledge
    $display("[TB] starvation bound");
    nGrants  = 0;
    nIReady  = 0;
    bothHigh = 0;
    iReadyCyc[0] = 0;
    iReadyCyc[1] = 0;
    for (int k = 0; k < 10; k++) grantIsI[k] = 1'b0;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    for (int cyc = 1; cyc <= 36; cyc++) begin
      tick();
      if (IReady && DReady) bothHigh++;
      if (IReady) begin
        if (nIReady < 2) iReadyCyc[nIReady] = cyc;
        nIReady++;
        checkOutput("sv_irdata", IRData, 32'h40 ^ RDATA_SALT);
      end
      if (MemReq && nGrants < 10) begin
        grantIsI[nGrants] = (MemAdr == 32'h40);
        nGrants++;
      end
      MemAck   = MemReq;
      MemRData = MemAdr ^ RDATA_SALT;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int c = 0; c < 10 && Busy; c++) begin
      tick();
      MemAck   = MemReq;
      MemRData = MemAdr ^ RDATA_SALT;
    end
    MemAck = 1'b0;
    checkOutput("sv_drained", {31'h0, Busy}, 32'h0);
    checkOutput("sv_ngrants", nGrants, 32'd10);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("sv_grant%0d_is_i", k), {31'h0, grantIsI[k]},
                  (k == 4 || k == 9) ? 32'h1 : 32'h0);
    end
    checkOutput("sv_nireadys", (nIReady >= 2) ? 32'd1 : 32'd0, 32'd1);
    checkOutput("sv_iready_gap", iReadyCyc[1] - iReadyCyc[0], 32'd15);
    checkOutput("sv_both_ready", bothHigh, 32'd0);
    tick();

    // Reset in the middle of an access
    $display("[TB] reset mid-access");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
    tick();
    checkOutput("ra_memreq_before", {31'h0, MemReq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ra_memreq", {31'h0, MemReq}, 32'h0);
    checkOutput("ra_busy", {31'h0, Busy}, 32'h0);
    checkOutput("ra_memadr", MemAdr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("ra_quiet_c%0d", c), {29'h0, Busy, IReady, DReady}, 32'h0);
    end
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("ra_new_adr", MemAdr, 32'h600);
    checkOutput("ra_new_req", {31'h0, MemReq}, 32'h1);
    tick();
    checkOutput("ra_wait_req", {30'h0, MemReq, IReady}, 32'h2);
    MemAck   = 1'b1;
    MemRData = 32'h0BAD_F00D;
    tick();
    checkOutput("ra_iready", {30'h0, IReady, DReady}, 32'h2);
    checkOutput("ra_irdata", IRData, 32'h0BAD_F00D);
    MemAck = 1'b0;
    IReq   = 1'b0;
    tick();
    checkOutput("ra_end_idle", {30'h0, Busy, IReady}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the instruction fetch unit and the load/store unit of the sample processor. It registers one request at a time, drives the memory port until the memory acknowledges, and returns the read data to the owning requester with a one-cycle Ready pulse. Data requests have priority over fetches. A streak counter bounds how long a pending fetch can be starved.

## Interface
- STREAK, 4: maximum consecutive data grants while IReq is pending before a fetch is forced through (legal range 1..15).
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IReq  in  1  fetch request; held with IAdr until IReady.
- IAdr  in  32  fetch byte address (word-aligned).
- IReady  out  1  one-cycle pulse; the fetch has completed.
- IRData  out  32  fetched word; valid when IReady is 1, held until the next fetch response.
- DReq  in  1  data request (LSU MemEn); held with payload until DReady.
- DWrite  in  1  1 = store, 0 = load.
- DAdr  in  32  data byte address.
- DWData  in  32  lane-aligned store data.
- DByteEn  in  4  store byte enables.
- DReady  out  1  one-cycle pulse; the data access has completed.
- DRData  out  32  raw load word; valid with DReady on loads; 0 after a store response.
- MemReq  out  1  memory access active.
- MemWrite  out  1  store access.
- MemAdr  out  32  registered address.
- MemWData  out  32  registered store data.
- MemByteEn  out  4  registered byte enables; 4'b0000 on reads.
- MemRData  in  32  memory read data; valid in the cycle MemAck is 1.
- MemAck  in  1  memory completes the access this cycle.
- Busy  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If DReq or IReq is high, select an owner, latch the owner's payload into the Mem* registers, and go to ACCESS.
  - Otherwise remain in IDLE.
- Selection:
  - Only one requester high: that requester wins.
  - Both high: D wins, unless streak == STREAK, in which case I wins.
- Streak counter (4 bits, saturating at STREAK):
  - Increments on a D grant made while IReq is high.
  - Clears on any I grant.
  - Clears on a D grant made while IReq is low.
- ACCESS:
  - MemReq = 1, and MemWrite, MemAdr, MemWData and MemByteEn are stable.
  - On MemAck, capture read data for the owner and go to RESP:
    - I owner: IRData ← MemRData.
    - D load: DRData ← MemRData.
    - D store: DRData ← 0.
  - Without MemAck, stay in ACCESS indefinitely; there is no timeout.
- RESP:
  - The owner's Ready is 1 for exactly this cycle, then go to IDLE.
- Fetch accesses force MemWrite = 0 and MemByteEn = 0.
- MemAck is ignored in IDLE and RESP.
- Requester contract:
  - A requester drops its Req, or presents a new request, in the cycle after its Ready.
  - If Req drops during ACCESS, the access still completes and Ready still pulses; the payload is already registered, so later changes to the input payload have no effect.
- Reset mid-access:
  - MemReq drops immediately (asynchronously) and the transaction is discarded.
  - The memory tolerates an aborted request.

## Timing
- Reset values: state = IDLE, streak = 0, and every output = 0 (MemReq, MemWrite, MemAdr, MemWData, MemByteEn, IReady, DReady, IRData, DRData, Busy).
- Latency, with the request first seen in IDLE at cycle 0:
  - MemReq asserts at cycle 1.
  - With MemAck at cycle 1+w (w = memory wait states), Ready pulses at cycle 2+w.
  - Minimum latency is 2 cycles.
- Throughput: at most one access every 3 cycles (IDLE, ACCESS, RESP).
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- IReady and DReady are never high in the same cycle.
- Simultaneous requests in the same IDLE cycle are resolved by the Selection rule above. The losing request stays pending with no side effect.

## Test plan
- Single load: DReq=1, DWrite=0, DAdr=0x100; MemAck at cycle 1 with MemRData=0xDEADBEEF.
  - Expect MemReq at cycle 1 with MemAdr=0x100 and MemByteEn=0.
  - Expect DReady at cycle 2 with DRData=0xDEADBEEF.
- Store with 2 wait states: DWrite=1, DAdr=0x204, DWData=0x0000AB00, DByteEn=4'b0010; MemAck at cycle 3.
  - Expect MemReq high for cycles 1–3 with the payload stable.
  - Expect DReady at cycle 4 with DRData=0.
- Contention: IReq=1 (IAdr=0x40) and DReq=1 asserted together.
  - Expect D served first, then I.
  - Expect IReady with IRData equal to the word at 0x40.
- Starvation bound: IReq and DReq held high continuously, STREAK=4, immediate MemAck.
  - Expect the grant order D,D,D,D,I,D,D,D,D,I…
  - Expect the gap between IReady pulses to be exactly 15 cycles.
- Reset mid-access: assert reset_n=0 during ACCESS.
  - Expect MemReq, Busy and MemAdr at 0 in the same cycle.
  - After release, expect a new request to start cleanly from IDLE with no stale Ready pulse.
- Spurious MemAck in IDLE: no requests pending, MemAck=1.
  - Expect no Ready pulse, IRData and DRData unchanged, and the state to remain IDLE.
